// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage controller and muldiv_unit.
// The controller drives the request side; the unit drives status and result.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, b, flush, input ready, busy, done, result);
    modport slave  (input start, op, a, b, flush, output ready, busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider working on operand magnitudes, one bit per cycle, followed by a
// single sign-fixup cycle. Divide-by-zero and signed overflow finish at accept.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state;
    op_e              op_q;
    logic [CNTW-1:0]  cnt;
    // Multiplicand (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0] operand;
    // Multiply: {acc_hi, acc_lo} is the product with the multiplier shifting
    // out of acc_lo. Divide: acc_hi is the remainder, acc_lo the dividend
    // shifting out while quotient bits shift in.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             neg_q;
    logic             neg_r;

    op_e              op_in;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             special;
    logic [WIDTH-1:0] special_val;

    logic             is_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fix_val;

    assign op_in = op_e'(bus.op);

    // Accept-side decode: operand signedness, magnitudes and early-finish cases.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        special     = 1'b0;
        special_val = '0;
        a_signed    = !(op_in inside {OP_MULHU, OP_DIVU, OP_REMU});
        b_signed    = a_signed && (op_in != OP_MULHSU);
        a_neg       = a_signed && bus.a[WIDTH-1];
        b_neg       = b_signed && bus.b[WIDTH-1];
        a_mag       = a_neg ? -bus.a : bus.a;
        b_mag       = b_neg ? -bus.b : bus.b;
        if (bus.op[2] && bus.b == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            special     = 1'b1;
            special_val = bus.op[1] ? bus.a : '1;
        end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                     bus.a == INT_MIN && bus.b == '1) begin
            // Signed overflow: quotient wraps to the dividend, remainder zero.
            special     = 1'b1;
            special_val = bus.op[1] ? '0 : bus.a;
        end
    end

    // Per-iteration step values and the final sign-corrected result.
    always_comb begin
        is_div    = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Working remainder is WIDTH+1 bits; after a successful subtract it
        // is always below the divisor, so WIDTH bits hold it between steps.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, operand};
        div_sub   = div_shift[WIDTH-1:0] - operand;
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -acc_lo : acc_lo;
        rem_fix   = neg_r ? -acc_hi : acc_hi;
        case (op_q)
            OP_MUL:                       fix_val = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_val = quo_fix;
            default:                      fix_val = rem_fix;
        endcase
    end

    // Control FSM, iteration datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_MUL;
            cnt        <= '0;
            operand    <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            bus.ready  <= 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else if (bus.flush) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q <= op_in;
                        if (special) begin
                            state      <= DONE;
                            bus.result <= special_val;
                            bus.done   <= 1'b1;
                            bus.ready  <= 1'b1;
                            bus.busy   <= 1'b0;
                        end else begin
                            state     <= CALC;
                            cnt       <= CNTW'(WIDTH);
                            neg_q     <= a_neg ^ b_neg;
                            neg_r     <= a_neg;
                            acc_hi    <= '0;
                            operand   <= bus.op[2] ? b_mag : a_mag;
                            acc_lo    <= bus.op[2] ? a_mag : b_mag;
                            bus.ready <= 1'b0;
                            bus.busy  <= 1'b1;
                        end
                    end else begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                        bus.busy  <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt - CNTW'(1);
                    if (is_div) begin
                        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CNTW'(1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state      <= DONE;
                    bus.result <= fix_val;
                    bus.done   <= 1'b1;
                    bus.ready  <= 1'b1;
                    bus.busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush, reset,
// back-to-back issue and randomized operations against an arithmetic model.
module tb_muldiv_unit;
    localparam int          WIDTH = 32;
    localparam logic [31:0] MIN   = 32'h8000_0000;
    localparam logic [2:0]  MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0]  DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
    muldiv_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == DIV || op == REM) && a == MIN && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return MIN;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one op when ready, then follow it to done; ends inside the done cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int          lat_exp, n, busy_n, chg;
        logic [31:0] held;
        lat_exp = is_special(op, a, b) ? 1 : WIDTH + 2;
        n = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, " ready"}, 32'(bus.ready), 32'd1);
        held      = bus.result;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.a     = $urandom();
        bus.b     = $urandom();
        n      = 1;
        busy_n = 0;
        chg    = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_n++;
            if (bus.result !== held) chg++;
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat_exp));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(lat_exp - 1));
        check({tag, " result early change"}, 32'(chg), 32'd0);
        check({tag, " result"}, bus.result, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        logic [2:0]  op;
        logic [31:0] a, b;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);

        run_op("MUL 7*-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("MULH min*min", MULH, MIN, MIN, 32'h4000_0000);
        run_op("MULHU max*max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("MULHSU -1*2", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_op("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14);
        run_op("REMU 100/7", REMU, 32'd100, 32'd7, 32'd2);
        run_op("DIVU 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("REM 5/0", REM, 32'd5, 32'd0, 32'd5);
        run_op("DIV ovf", DIV, MIN, 32'hFFFF_FFFF, MIN);
        run_op("REM ovf", REM, MIN, 32'hFFFF_FFFF, 32'd0);

        // Back-to-back: the next start is presented in the DONE cycle.
        run_op("b2b MUL 5*6", MUL, 32'd5, 32'd6, 32'd30);
        check("b2b done cycle ready", 32'({bus.done, bus.ready}), 32'd3);
        run_op("b2b DIVU 9/3", DIVU, 32'd9, 32'd3, 32'd3);

        // Flush a DIV at t+10; the next MUL must see the normal latency.
        prev      = bus.result;
        bus.start = 1'b1;
        bus.op    = DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush ready", 32'(bus.ready), 32'd1);
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush done", 32'(bus.done), 32'd0);
        check("flush result kept", bus.result, prev);
        run_op("post-flush MUL 3*4", MUL, 32'd3, 32'd4, 32'd12);

        // Reset five cycles into a MULHU.
        bus.start = 1'b1;
        bus.op    = MULHU;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset ready", 32'(bus.ready), 32'd1);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset result", bus.result, 32'd0);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op($sformatf("rand%0d op%0d %h,%h", i, op, a, b), op, a, b, ref_result(op, a, b));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit implementing the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a parametrised datapath width. It replaces the single-cycle combinational `*` and `/` paths in the core ALU with a shift-add multiplier and a restoring divider, one bit per cycle. It sits beside the ALU in the execute stage. The controller stalls the PC while `busy` is high and writes `result` to the register file on `done`.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 4 and even.
- CNTW, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  request; sampled only when `ready`=1.
- op  in  3  operation, equal to instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand; sampled with `start`.
- b  in  WIDTH  rs2 operand; sampled with `start`.
- flush  in  1  abort the current operation; no `done` is produced.
- ready  out  1  unit accepts `start` this cycle.
- busy  out  1  operation in progress.
- done  out  1  single-cycle pulse; `result` is valid.
- result  out  WIDTH  result of the last completed operation; held until the next `done`.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- `ready` = (IDLE or DONE).
- `busy` = (CALC or FIXUP).
- `done` = DONE.
- Accept rule: `start`=1 with `ready`=1 and `flush`=0 latches `op`, `a` and `b`.
  - Special case → DONE directly.
  - Otherwise, operand magnitudes and result sign are captured, counter loads WIDTH, next state CALC.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- CALC, multiply: 2·WIDTH-bit accumulator, shift-add on magnitudes, one multiplier bit per cycle.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle, remainder WIDTH+1 bits.
- Counter decrements each CALC cycle; at 1 → FIXUP.
- FIXUP applies sign correction, two's complement negate:
  - Product negated if the operand signs differ (signed operands only).
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection: MUL → low WIDTH bits; MULH/MULHSU/MULHU → high WIDTH bits.
- FIXUP registers `result` → DONE.
- DONE lasts one cycle → IDLE, or → CALC/DONE if a new `start` is accepted in that cycle.
- Special cases (no CALC, `result` registered at accept):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `a`.
  - Signed overflow (DIV/REM, a = 1 followed by WIDTH-1 zeros, b = all ones): DIV → `a`; REM → 0.
- Multiplication by zero takes the full latency (no early-out).
- `flush`: from any state → IDLE next cycle. `result` is unchanged. A `start` in the same cycle is ignored.
- Priority: reset > flush > start.

## Timing
- Reset: state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, counter 0.
- `start` accepted in cycle t, normal path:
  - CALC in cycles t+1 … t+WIDTH.
  - FIXUP in cycle t+WIDTH+1.
  - `done`=1 in cycle t+WIDTH+2 (t+34 for WIDTH=32).
- `start` accepted in cycle t, special case: `done`=1 in cycle t+1.
- `result` changes only on the edge that enters DONE. It is stable for the whole `done` cycle and afterwards.
- Back-to-back: a `start` accepted during the DONE cycle begins the next operation with no idle bubble.
- `a`, `b` and `op` may change freely after the accept cycle.
- `flush` in cycle t → IDLE in t+1, `ready`=1 in t+1. A `done` scheduled for t+1 or later is suppressed.
- Reset asserted mid-operation → reset values in the next cycle.

## Test plan
- WIDTH=32, MUL a=7, b=0xFFFFFFFD (−3), start at t → `done` only at t+34, `result`=0xFFFFFFEB. `busy`=1 for t+1…t+33.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- Division and remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF with `done` at t+1.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Flush: DIV started at t, `flush` at t+10 → no `done` ever for that op, `ready`=1 at t+11, `result` unchanged. New MUL 3 × 4 started at t+11 → 12 at t+45.
- Reset and back-to-back:
  - Reset at t+5 of a MULHU → all outputs at reset values in t+6.
  - `start` (DIVU 9 / 3) held high in the DONE cycle of a prior op → accepted in that cycle, `done` with 3 exactly 34 cycles later.
